data_mem_ctrl: RTL and testbench

//  External data memory that sits directly downstream of the L1 data cache. It serves the

---
 rtl/data_mem_ctrl_pkg.sv | 16 +
 rtl/data_mem_ctrl_if.sv | 23 ++
 rtl/data_mem_ctrl_line_ram.sv | 24 ++
 rtl/data_mem_ctrl.sv | 106 ++++++++++
 tb/tb_data_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the line-wide data memory behind the L1 data cache.
package data_mem_ctrl_pkg;

   localparam int LINE_OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   function automatic int idx_bits(input int depth_lines);
      return $clog2(depth_lines);
   endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Cache refill / write-back bus between the L1 data cache (master) and the data memory (slave).
interface data_mem_ctrl_if #(
   parameter int LINE_BITS = 256,
   parameter int ADDR_BITS = 32
);
   logic [ADDR_BITS-1:0] addr_i;
   logic [LINE_BITS-1:0] data_i;
   logic                 cs_i;
   logic                 we_i;
   logic [LINE_BITS-1:0] data_o;
   logic                 ack_o;
   logic                 busy_o;

   modport master (
      output addr_i, data_i, cs_i, we_i,
      input  data_o, ack_o, busy_o
   );

   modport slave (
      input  addr_i, data_i, cs_i, we_i,
      output data_o, ack_o, busy_o
   );
endinterface

// File: rtl/data_mem_ctrl_line_ram.sv
// Line storage: synchronous write, asynchronous read. Contents survive reset.
module data_mem_ctrl_line_ram #(
   parameter int DEPTH_LINES = 512,
   parameter int LINE_BITS   = 256,
   localparam int IDX_BITS   = $clog2(DEPTH_LINES)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [IDX_BITS-1:0]  idx,
   input  logic [LINE_BITS-1:0] wdata,
   output logic [LINE_BITS-1:0] rdata
);

   logic [LINE_BITS-1:0] mem [DEPTH_LINES];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding line memory: accepts one request, completes it LATENCY edges later
// with a one-cycle ack and, for reads, the line on data_o.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no request; a high cs_i is captured at the next edge
// ST_WAIT | request held in req_*; counter runs down to zero
// ST_ACK  | access done, ack_o high for this single cycle
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int LINE_BITS   = 256,
   parameter int DEPTH_LINES = 512,
   parameter int LATENCY     = 10
) (
   input logic             clk,
   input logic             rst,
   data_mem_ctrl_if.slave  bus
);

   localparam int IDX_BITS = idx_bits(DEPTH_LINES);
   localparam int CNT_BITS = $clog2(LATENCY + 1);
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

   state_t               state;
   logic [CNT_BITS-1:0]  cnt;
   logic [IDX_BITS-1:0]  req_idx;
   logic [LINE_BITS-1:0] req_data;
   logic                 req_we;
   logic                 ack_q;
   logic                 busy_q;
   logic [LINE_BITS-1:0] data_q;

   logic                 access;
   logic                 ram_we;
   logic [LINE_BITS-1:0] ram_rdata;

   // The access happens on the edge that moves WAIT to ACK; a reset on that edge
   // must suppress the write so an aborted request leaves the array untouched.
   assign access = (state == ST_WAIT) && (cnt == '0);
   assign ram_we = access && req_we && !rst;

   data_mem_ctrl_line_ram #(
      .DEPTH_LINES (DEPTH_LINES),
      .LINE_BITS   (LINE_BITS)
   ) u_line_ram (
      .clk   (clk),
      .we    (ram_we),
      .idx   (req_idx),
      .wdata (req_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         req_idx  <= '0;
         req_data <= '0;
         req_we   <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         data_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               ack_q <= 1'b0;
               if (bus.cs_i) begin
                  req_idx  <= bus.addr_i[IDX_BITS+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
                  req_data <= bus.data_i;
                  req_we   <= bus.we_i;
                  cnt      <= CNT_LOAD;
                  busy_q   <= 1'b1;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  ack_q <= 1'b1;
                  state <= ST_ACK;
                  if (!req_we) begin
                     data_q <= ram_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_ACK: begin
               ack_q  <= 1'b0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               ack_q  <= 1'b0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ack_o  = ack_q;
   assign bus.busy_o = busy_q;
   assign bus.data_o = data_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a LATENCY=10 and a LATENCY=1 instance share one stimulus stream
// and are checked every cycle against a timestamp-based reference model.
module tb_data_mem_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cs  = 1'b0;
   logic         we  = 1'b0;
   logic [31:0]  addr = '0;
   logic [255:0] data = '0;

   always #5 clk = ~clk;

   data_mem_ctrl_if #(.LINE_BITS(256), .ADDR_BITS(32)) if10 ();
   data_mem_ctrl_if #(.LINE_BITS(256), .ADDR_BITS(32)) if1  ();

   assign if10.cs_i   = cs;
   assign if10.we_i   = we;
   assign if10.addr_i = addr;
   assign if10.data_i = data;
   assign if1.cs_i    = cs;
   assign if1.we_i    = we;
   assign if1.addr_i  = addr;
   assign if1.data_i  = data;

   data_mem_ctrl #(.LINE_BITS(256), .DEPTH_LINES(512), .LATENCY(10)) u_d10 (
      .clk (clk), .rst (rst), .bus (if10)
   );
   data_mem_ctrl #(.LINE_BITS(256), .DEPTH_LINES(512), .LATENCY(1)) u_d1 (
      .clk (clk), .rst (rst), .bus (if1)
   );

   int n_total  = 0;
   int n_passed = 0;

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      n_total++;
      if (got === exp) n_passed++;
      else $display("FAIL %s got %h exp %h", nm, got, exp);
   endtask

   // Reference model: each request is a timestamp; outputs follow from its age in edges.
   int           lat [2] = '{10, 1};
   logic [255:0] mmem [2][512];
   bit           mval [2][512];
   bit           act [2];
   longint       acc_cyc [2];
   int           ridx [2];
   bit           rwe [2];
   logic [255:0] rdat [2];
   bit           e_ack [2];
   bit           e_busy [2];
   logic [255:0] e_data [2];
   bit           e_known [2];
   longint       cyc = 0;
   bit           model_on = 1'b0;

   initial begin
      for (int d = 0; d < 2; d++) begin
         act[d] = 1'b0;
         for (int i = 0; i < 512; i++) mval[d][i] = 1'b0;
      end
   end

   always @(posedge clk) begin
      cyc++;
      if (rst) model_on = 1'b1;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            act[d]     = 1'b0;
            e_ack[d]   = 1'b0;
            e_busy[d]  = 1'b0;
            e_data[d]  = '0;
            e_known[d] = 1'b1;
         end else begin
            bit     idle_before;
            longint age;
            idle_before = !act[d];
            if (act[d]) begin
               age = cyc - acc_cyc[d];
               if (age == longint'(lat[d])) begin
                  if (rwe[d]) begin
                     mmem[d][ridx[d]] = rdat[d];
                     mval[d][ridx[d]] = 1'b1;
                  end else begin
                     e_data[d]  = mmem[d][ridx[d]];
                     e_known[d] = mval[d][ridx[d]];
                  end
               end
               if (age == longint'(lat[d] + 1)) act[d] = 1'b0;
            end
            if (idle_before && cs) begin
               act[d]     = 1'b1;
               acc_cyc[d] = cyc;
               ridx[d]    = int'((addr / 32'd32) % 32'd512);
               rwe[d]     = we;
               rdat[d]    = data;
            end
            e_busy[d] = act[d];
            e_ack[d]  = act[d] && ((cyc - acc_cyc[d]) == longint'(lat[d]));
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk($sformatf("ack L10 cyc%0d", cyc), 256'(if10.ack_o), 256'(e_ack[0]));
         chk($sformatf("busy L10 cyc%0d", cyc), 256'(if10.busy_o), 256'(e_busy[0]));
         if (e_known[0]) chk($sformatf("data L10 cyc%0d", cyc), if10.data_o, e_data[0]);
         chk($sformatf("ack L1 cyc%0d", cyc), 256'(if1.ack_o), 256'(e_ack[1]));
         chk($sformatf("busy L1 cyc%0d", cyc), 256'(if1.busy_o), 256'(e_busy[1]));
         if (e_known[1]) chk($sformatf("data L1 cyc%0d", cyc), if1.data_o, e_data[1]);
      end
   end

   task automatic idle_wait();
      int n;
      n = 0;
      cs = 1'b0;
      @(negedge clk);
      while ((if10.busy_o || if1.busy_o) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("idle_timeout", 256'(1), 256'(0));
   endtask

   task automatic issue(input bit w, input logic [31:0] a, input logic [255:0] dt,
                        output longint k);
      @(negedge clk);
      cs = 1'b1; we = w; addr = a; data = dt;
      @(posedge clk);
      #1 k = cyc;
      @(negedge clk);
      cs = 1'b0;
   endtask

   task automatic wait_ack10(input longint k, output logic [255:0] dq, output int seen);
      seen = -1;
      dq   = '0;
      for (int i = 0; i < 30; i++) begin
         if (if10.ack_o) begin
            seen = int'(cyc - k);
            dq   = if10.data_o;
            break;
         end
         @(negedge clk);
      end
   endtask

   localparam logic [255:0] DB = {8{32'hDEADBEEF}};
   localparam logic [255:0] PW = {8{32'h0123_4567}};
   localparam logic [255:0] QW = {8{32'hCAFE_F00D}};
   localparam logic [255:0] SW = {8{32'h5A5A_1234}};
   localparam logic [255:0] RW = {8{32'hBAD0_BAD0}};

   initial begin
      longint       k;
      logic [255:0] dq;
      int           seen;
      int           acks;

      repeat (3) @(negedge clk);
      chk("reset_ack", 256'(if10.ack_o), 256'(0));
      chk("reset_busy", 256'(if10.busy_o), 256'(0));
      chk("reset_data", if10.data_o, '0);
      chk("reset_data_l1", if1.data_o, '0);
      rst = 1'b0;

      // 1: write, latency and busy window
      issue(1'b1, 32'h0000_0040, DB, k);
      chk("t1_busy_first", 256'(if10.busy_o), 256'(1));
      wait_ack10(k, dq, seen);
      chk("t1_latency", 256'(seen), 256'(10));
      chk("t1_busy_at_ack", 256'(if10.busy_o), 256'(1));
      @(negedge clk);
      chk("t1_ack_one_cycle", 256'(if10.ack_o), 256'(0));
      chk("t1_busy_after", 256'(if10.busy_o), 256'(0));
      idle_wait();

      // 2: read back, data held
      issue(1'b0, 32'h0000_0040, '0, k);
      wait_ack10(k, dq, seen);
      chk("t2_latency", 256'(seen), 256'(10));
      chk("t2_data", dq, DB);
      repeat (3) @(negedge clk);
      chk("t2_data_held", if10.data_o, DB);
      idle_wait();

      // 3: line offset ignored, upper bits wrap
      issue(1'b0, 32'h0000_005F, '0, k);
      wait_ack10(k, dq, seen);
      chk("t3_offset_data", dq, DB);
      idle_wait();
      issue(1'b1, 32'h0000_4000, PW, k);
      wait_ack10(k, dq, seen);
      idle_wait();
      issue(1'b0, 32'h0000_0000, '0, k);
      wait_ack10(k, dq, seen);
      chk("t3_wrap_data", dq, PW);
      idle_wait();

      // 4: inputs change in flight, cs held for back-to-back
      @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = 32'h0000_0040; data = '0;
      @(posedge clk);
      #1 k = cyc;
      @(negedge clk);
      addr = 32'h0000_0000; we = 1'b1; data = QW;
      wait_ack10(k, dq, seen);
      chk("t4_latency", 256'(seen), 256'(10));
      chk("t4_orig_data", dq, DB);
      @(negedge clk);
      chk("t4_idle_gap", 256'(if10.busy_o), 256'(0));
      @(negedge clk);
      chk("t4_next_accept", 256'(if10.busy_o), 256'(1));
      cs = 1'b0;
      idle_wait();
      issue(1'b0, 32'h0000_0000, '0, k);
      wait_ack10(k, dq, seen);
      chk("t4_second_write", dq, QW);
      idle_wait();

      // 5: reset five cycles into a write
      issue(1'b1, 32'h0000_0080, SW, k);
      wait_ack10(k, dq, seen);
      idle_wait();
      issue(1'b1, 32'h0000_0080, RW, k);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      acks = 0;
      for (int i = 0; i < 15; i++) begin
         if (if10.ack_o) acks++;
         @(negedge clk);
      end
      chk("t5_no_ack", 256'(acks), 256'(0));
      chk("t5_busy", 256'(if10.busy_o), 256'(0));
      issue(1'b0, 32'h0000_0080, '0, k);
      wait_ack10(k, dq, seen);
      chk("t5_prior_data", dq, SW);
      idle_wait();

      // 6: LATENCY=1 instance
      @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = 32'h0000_0040;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t6_no_ack_yet", 256'(if1.ack_o), 256'(0));
      cs = 1'b0;
      @(negedge clk);
      chk("t6_ack", 256'(if1.ack_o), 256'(1));
      chk("t6_data", if1.data_o, DB);
      idle_wait();

      // Random traffic over a few lines with random upper address bits
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a;
         @(negedge clk);
         a       = $urandom;
         a[13:5] = 9'($urandom_range(0, 7));
         cs   = ($urandom_range(0, 1) == 1);
         we   = ($urandom_range(0, 1) == 1);
         addr = a;
         data = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
         rst  = ($urandom_range(0, 79) == 0);
      end
      rst = 1'b0;
      idle_wait();
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1);
   end

endmodule
